// File: rtl/ram_responder.sv
// 256x8 RAM responder for the CPU control unit: address register, registered read path, byte-stream loader.
// Optional MMIO output port at MMIO_ADDR is enabled by defining MMIO_OUT_EN.
module ram_responder #(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned MMIO_ADDR = 8'hFF
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [DATA_W-1:0] i_bus,
  output logic [DATA_W-1:0] o_bus,
  output logic              o_busOE,
  input  logic [ADDR_W-1:0] i_pc,
  input  logic              i_ctrlPCNOe,
  input  logic              i_ctrlRamAddressEn,
  input  logic              i_ctrlRamWriteEn,
  input  logic              i_ctrlRamOE,
  input  logic              i_ctrlRamReadDataSelect,
  output logic [DATA_W-1:0] o_instruction,
  input  logic              i_loadMode,
  input  logic              i_loadValid,
  input  logic [DATA_W-1:0] i_loadData,
  output logic              o_loadReady,
  output logic              o_loadDone,
  output logic              o_cpuReset,
  output logic [DATA_W-1:0] o_outPort,
  output logic              o_outStrobe
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    S_RUN,
    S_LOAD,
    S_DONE
  } state_t;

  state_t             r_state;
  state_t             w_nextState;
  logic [ADDR_W-1:0]  r_ptr;
  logic [ADDR_W-1:0]  r_address;
  logic [DATA_W-1:0]  r_readData;
  logic [DATA_W-1:0]  r_instruction;
  logic               r_loadReady;
  logic               r_loadDone;
  logic               r_cpuReset;
  logic [DATA_W-1:0]  r_mem [DEPTH];

  logic [ADDR_W-1:0]  w_addr;
  logic [DATA_W-1:0]  w_rdData;
  logic               w_run;
  logic               w_loadFire;
  logic               w_cpuWrite;
  logic               w_ramCpuWrite;

  assign w_run      = (r_state == S_RUN);
  assign w_addr     = i_ctrlPCNOe ? r_address : i_pc;
  assign w_loadFire = (r_state == S_LOAD) & i_loadMode & i_loadValid & r_loadReady;
  assign w_cpuWrite = w_run & i_ctrlRamWriteEn & i_ctrlPCNOe;

`ifdef MMIO_OUT_EN
  localparam logic [ADDR_W-1:0] L_MMIO = ADDR_W'(MMIO_ADDR);

  logic [DATA_W-1:0] r_outPort;
  logic              r_outStrobe;
  logic              w_mmioHit;

  // CPU writes to the port address are diverted away from RAM.
  assign w_mmioHit     = (r_address == L_MMIO);
  assign w_ramCpuWrite = w_cpuWrite & ~w_mmioHit;
  assign w_rdData      = (w_addr == L_MMIO) ? r_outPort : r_mem[w_addr];

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_outPort   <= '0;
      r_outStrobe <= 1'b0;
    end else begin
      r_outStrobe <= w_cpuWrite & w_mmioHit;
      if (w_cpuWrite && w_mmioHit) begin
        r_outPort <= i_bus;
      end
    end
  end

  assign o_outPort   = r_outPort;
  assign o_outStrobe = r_outStrobe;
`else
  assign w_ramCpuWrite = w_cpuWrite;
  assign w_rdData      = r_mem[w_addr];
  assign o_outPort     = '0;
  assign o_outStrobe   = 1'b0;
`endif

  // Single write port shared by the loader (LOAD only) and the CPU (RUN only).
  always_ff @(posedge i_clk) begin
    if (w_loadFire) begin
      r_mem[r_ptr] <= i_loadData;
    end else if (w_ramCpuWrite) begin
      r_mem[r_address] <= i_bus;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_address     <= '0;
      r_readData    <= '0;
      r_instruction <= '0;
    end else if (w_run) begin
      if (i_ctrlRamAddressEn) begin
        r_address <= ADDR_W'(i_bus);
      end
      r_readData <= w_rdData;
      if (!i_ctrlPCNOe) begin
        r_instruction <= w_rdData;
      end
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_RUN: begin
        if (i_loadMode) w_nextState = S_LOAD;
      end
      S_LOAD: begin
        if (!i_loadMode) begin
          w_nextState = S_RUN;
        end else if (w_loadFire && (r_ptr == {ADDR_W{1'b1}})) begin
          w_nextState = S_DONE;
        end
      end
      S_DONE: begin
        if (!i_loadMode) w_nextState = S_RUN;
      end
      default: w_nextState = S_RUN;
    endcase
  end

  // Handshake/status outputs are registered from the next state.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= S_RUN;
      r_ptr       <= '0;
      r_loadReady <= 1'b0;
      r_loadDone  <= 1'b0;
      r_cpuReset  <= 1'b0;
    end else begin
      r_state     <= w_nextState;
      r_loadReady <= (w_nextState == S_LOAD);
      r_loadDone  <= (w_nextState == S_DONE);
      r_cpuReset  <= (w_nextState != S_RUN);
      if (w_run && i_loadMode) begin
        r_ptr <= '0;
      end else if (w_loadFire) begin
        r_ptr <= r_ptr + 1'b1;
      end
    end
  end

  assign o_bus         = r_readData;
  assign o_busOE       = i_ctrlRamOE & ~i_ctrlRamReadDataSelect & w_run;
  assign o_instruction = r_instruction;
  assign o_loadReady   = r_loadReady;
  assign o_loadDone    = r_loadDone;
  assign o_cpuReset    = i_reset | r_cpuReset;

endmodule

// File: tb/tb_ram_responder.sv
// Directed bench for ram_responder: reset, load, fetch, data access, same-cycle address/write, MMIO, reset mid-load.
module tb_ram_responder;

  logic       clk;
  logic       rst;
  logic [7:0] bus_in;
  logic [7:0] bus_out;
  logic       bus_oe;
  logic [7:0] pc;
  logic       pcnoe;
  logic       addr_en;
  logic       wr_en;
  logic       ram_oe;
  logic       rd_sel;
  logic [7:0] instr;
  logic       load_mode;
  logic       load_valid;
  logic [7:0] load_data;
  logic       load_ready;
  logic       load_done;
  logic       cpu_reset;
  logic [7:0] out_port;
  logic       out_strobe;

  int checks;
  int failures;

  ram_responder dut (
    .i_clk                  (clk),
    .i_reset                (rst),
    .i_bus                  (bus_in),
    .o_bus                  (bus_out),
    .o_busOE                (bus_oe),
    .i_pc                   (pc),
    .i_ctrlPCNOe            (pcnoe),
    .i_ctrlRamAddressEn     (addr_en),
    .i_ctrlRamWriteEn       (wr_en),
    .i_ctrlRamOE            (ram_oe),
    .i_ctrlRamReadDataSelect(rd_sel),
    .o_instruction          (instr),
    .i_loadMode             (load_mode),
    .i_loadValid            (load_valid),
    .i_loadData             (load_data),
    .o_loadReady            (load_ready),
    .o_loadDone             (load_done),
    .o_cpuReset             (cpu_reset),
    .o_outPort              (out_port),
    .o_outStrobe            (out_strobe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [7:0] a, output logic [7:0] d);
    pc    = a;
    pcnoe = 1'b0;
    step();
    d     = instr;
    pcnoe = 1'b1;
  endtask

  task automatic cpu_write(input logic [7:0] a, input logic [7:0] d);
    pcnoe   = 1'b1;
    addr_en = 1'b1;
    bus_in  = a;
    step();
    addr_en = 1'b0;
    wr_en   = 1'b1;
    bus_in  = d;
    step();
    wr_en   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    checks++;
    if (bus_out !== 8'h00) begin failures++; $display("FAIL reset_bus got=%h exp=00", bus_out); end
    checks++;
    if (instr !== 8'h00) begin failures++; $display("FAIL reset_instr got=%h exp=00", instr); end
    checks++;
    if (load_ready !== 1'b0 || load_done !== 1'b0) begin
      failures++; $display("FAIL reset_load got=%b%b exp=00", load_ready, load_done);
    end
    checks++;
    if (cpu_reset !== 1'b1) begin failures++; $display("FAIL reset_cpurst got=%b exp=1", cpu_reset); end
    checks++;
    if (out_port !== 8'h00 || out_strobe !== 1'b0) begin
      failures++; $display("FAIL reset_mmio got=%h/%b exp=00/0", out_port, out_strobe);
    end
    @(negedge clk);
    rst = 1'b0;
    step();
    checks++;
    if (cpu_reset !== 1'b0) begin failures++; $display("FAIL run_cpurst got=%b exp=0", cpu_reset); end
  endtask

  task automatic test_load();
    logic [7:0] d;
    logic [7:0] exp;
    int ok_ready;
    int ok_rst;
    load_mode = 1'b1;
    ram_oe    = 1'b1;
    step();
    checks++;
    if (bus_oe !== 1'b0) begin failures++; $display("FAIL load_busoe got=%b exp=0", bus_oe); end
    ok_ready = 0;
    ok_rst   = 0;
    for (int k = 0; k < 256; k++) begin
      if (load_ready === 1'b1) ok_ready++;
      if (cpu_reset === 1'b1) ok_rst++;
      load_valid = 1'b1;
      load_data  = 8'(k);
      step();
    end
    load_valid = 1'b0;
    ram_oe     = 1'b0;
    checks++;
    if (ok_ready != 256) begin failures++; $display("FAIL load_accepts got=%0d exp=256", ok_ready); end
    checks++;
    if (ok_rst != 256 || cpu_reset !== 1'b1) begin
      failures++; $display("FAIL load_cpurst got=%0d exp=256", ok_rst);
    end
    checks++;
    if (load_done !== 1'b1 || load_ready !== 1'b0) begin
      failures++; $display("FAIL load_done got=%b/%b exp=1/0", load_done, load_ready);
    end
    load_mode = 1'b0;
    step();
    checks++;
    if (load_done !== 1'b0 || cpu_reset !== 1'b0) begin
      failures++; $display("FAIL load_exit got=%b/%b exp=0/0", load_done, cpu_reset);
    end
    for (int k = 0; k < 256; k++) begin
      fetch(8'(k), d);
      exp = 8'(k);
`ifdef MMIO_OUT_EN
      if (k == 255) exp = 8'h00;
`endif
      checks++;
      if (d !== exp) begin failures++; $display("FAIL load_mem[%0d] got=%h exp=%h", k, d, exp); end
    end
  endtask

  task automatic test_fetch();
    cpu_write(8'h10, 8'hA5);
    pc    = 8'h10;
    pcnoe = 1'b0;
    step();
    pcnoe = 1'b1;
    pc    = 8'h33;
    checks++;
    if (instr !== 8'hA5) begin failures++; $display("FAIL fetch got=%h exp=a5", instr); end
    step();
    step();
    checks++;
    if (instr !== 8'hA5) begin failures++; $display("FAIL fetch_hold got=%h exp=a5", instr); end
  endtask

  task automatic test_data_rw();
    pcnoe   = 1'b1;
    addr_en = 1'b1;
    bus_in  = 8'h20;
    step();
    addr_en = 1'b0;
    wr_en   = 1'b1;
    bus_in  = 8'h3C;
    step();
    checks++;
    if (bus_out !== 8'h20) begin failures++; $display("FAIL read_first got=%h exp=20", bus_out); end
    wr_en  = 1'b0;
    ram_oe = 1'b1;
    step();
    checks++;
    if (bus_out !== 8'h3C || bus_oe !== 1'b1) begin
      failures++; $display("FAIL data_read got=%h/%b exp=3c/1", bus_out, bus_oe);
    end
    rd_sel = 1'b1;
    #1;
    checks++;
    if (bus_oe !== 1'b0) begin failures++; $display("FAIL busoe_fetchsel got=%b exp=0", bus_oe); end
    rd_sel = 1'b0;
    ram_oe = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] d;
    pcnoe   = 1'b1;
    addr_en = 1'b1;
    bus_in  = 8'h05;
    step();
    wr_en  = 1'b1;
    bus_in = 8'h77;
    step();
    addr_en = 1'b0;
    bus_in  = 8'h99;
    step();
    wr_en = 1'b0;
    fetch(8'h05, d);
    checks++;
    if (d !== 8'h77) begin failures++; $display("FAIL same_cycle_mem5 got=%h exp=77", d); end
    fetch(8'h77, d);
    checks++;
    if (d !== 8'h99) begin failures++; $display("FAIL same_cycle_addr got=%h exp=99", d); end
    pc     = 8'h40;
    pcnoe  = 1'b0;
    wr_en  = 1'b1;
    bus_in = 8'h11;
    step();
    wr_en = 1'b0;
    fetch(8'h77, d);
    checks++;
    if (d !== 8'h99) begin failures++; $display("FAIL write_pc_src got=%h exp=99", d); end
  endtask

  task automatic test_mmio();
    logic [7:0] d;
    cpu_write(8'hFF, 8'h5A);
`ifdef MMIO_OUT_EN
    checks++;
    if (out_port !== 8'h5A || out_strobe !== 1'b1) begin
      failures++; $display("FAIL mmio_write got=%h/%b exp=5a/1", out_port, out_strobe);
    end
    step();
    checks++;
    if (out_strobe !== 1'b0) begin failures++; $display("FAIL mmio_pulse got=%b exp=0", out_strobe); end
`else
    checks++;
    if (out_port !== 8'h00 || out_strobe !== 1'b0) begin
      failures++; $display("FAIL mmio_tied got=%h/%b exp=00/0", out_port, out_strobe);
    end
`endif
    fetch(8'hFF, d);
    checks++;
    if (d !== 8'h5A) begin failures++; $display("FAIL mmio_read got=%h exp=5a", d); end
  endtask

  task automatic test_reset_midload();
    logic [7:0] d;
    load_mode = 1'b1;
    step();
    for (int k = 0; k < 10; k++) begin
      load_valid = 1'b1;
      load_data  = 8'hC0 + 8'(k);
      step();
    end
    load_valid = 1'b0;
    load_mode  = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (load_ready !== 1'b0 || cpu_reset !== 1'b1) begin
      failures++; $display("FAIL midload_rst got=%b/%b exp=0/1", load_ready, cpu_reset);
    end
    @(negedge clk);
    rst = 1'b0;
    step();
    checks++;
    if (cpu_reset !== 1'b0 || load_done !== 1'b0 || load_ready !== 1'b0) begin
      failures++; $display("FAIL midload_run got=%b%b%b exp=000", cpu_reset, load_done, load_ready);
    end
    for (int k = 0; k < 10; k++) begin
      fetch(8'(k), d);
      checks++;
      if (d !== 8'hC0 + 8'(k)) begin
        failures++; $display("FAIL midload_mem[%0d] got=%h exp=%h", k, d, 8'hC0 + 8'(k));
      end
    end
    fetch(8'd10, d);
    checks++;
    if (d !== 8'd10) begin failures++; $display("FAIL midload_mem[10] got=%h exp=0a", d); end
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    rst        = 1'b1;
    bus_in     = '0;
    pc         = '0;
    pcnoe      = 1'b1;
    addr_en    = 1'b0;
    wr_en      = 1'b0;
    ram_oe     = 1'b0;
    rd_sel     = 1'b0;
    load_mode  = 1'b0;
    load_valid = 1'b0;
    load_data  = '0;
    test_reset();
    test_load();
    test_fetch();
    test_data_rw();
    test_back_to_back();
    test_mmio();
    test_reset_midload();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_responder.md
Name: ram_responder

Overview:
- Memory-side responder to the CPU control unit's RAM strobes. Holds the 256x8 RAM, the memory address register and the registered read path.
- Supplies the instruction byte during fetch, and drives or accepts data-bus bytes for data accesses.
- Contains a byte-stream program loader that fills RAM while holding the CPU in reset.
- Sits between the 8-bit data bus, the PC and the control unit.

Parameters:
- ADDR_W, 8, address width; RAM depth = 2**ADDR_W.
- DATA_W, 8, data width.
- MMIO_ADDR, 8'hFF, address of the output port (used only with MMIO_OUT_EN).

Ports:
- i_clk  in  1  system clock, rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_bus  in  DATA_W  data bus value.
- o_bus  out  DATA_W  RAM read data toward the bus.
- o_busOE  out  1  o_bus valid for the bus driver.
- i_pc  in  ADDR_W  program counter value.
- i_ctrlPCNOe  in  1  0 = PC is address source (fetch), 1 = address register is the source.
- i_ctrlRamAddressEn  in  1  load address register from i_bus.
- i_ctrlRamWriteEn  in  1  write i_bus into RAM.
- i_ctrlRamOE  in  1  RAM read data onto bus.
- i_ctrlRamReadDataSelect  in  1  fetch phase; read data is the instruction.
- o_instruction  out  DATA_W  instruction byte toward the control unit.
- i_loadMode  in  1  request program-load mode.
- i_loadValid  in  1  loader byte valid.
- i_loadData  in  DATA_W  loader byte.
- o_loadReady  out  1  loader byte accepted when valid and ready are both high.
- o_loadDone  out  1  all 256 bytes loaded.
- o_cpuReset  out  1  hold the CPU (control unit, PC) in reset.
- o_outPort  out  DATA_W  MMIO output register.
- o_outStrobe  out  1  one-cycle pulse per MMIO write.

Behaviour:
- Reset (async, immediate) values:
  - r_address=0, r_readData=0, o_instruction=0.
  - FSM=RUN, load pointer=0, o_loadReady=0, o_loadDone=0.
  - o_cpuReset=1 while i_reset is high, then it follows the FSM.
  - o_outPort=0, o_outStrobe=0.
  - RAM contents are not reset.
- Effective address: s_addr = i_ctrlPCNOe ? r_address : i_pc.
- Address register: on a rising edge with i_ctrlRamAddressEn=1 in RUN, r_address <= i_bus.
- CPU write:
  - On a rising edge with i_ctrlRamWriteEn=1, i_ctrlPCNOe=1 and FSM=RUN: mem[r_address] <= i_bus.
  - The pre-edge r_address is used, so AddressEn and WriteEn in the same cycle write to the old address.
  - A write with i_ctrlPCNOe=0 is ignored.
- Read:
  - Every RUN cycle: r_readData <= mem[s_addr]. This gives 1-cycle latency.
  - Read-first: a write and a read of the same address in one cycle returns the old byte.
  - PC valid in step 0 gives the instruction on o_instruction throughout step 1.
- o_instruction <= mem[s_addr] on every edge where the previous cycle had i_ctrlPCNOe=0. It holds otherwise.
- o_bus = r_readData. o_busOE = i_ctrlRamOE & ~i_ctrlRamReadDataSelect & (FSM==RUN), combinational.
- FSM states: RUN, LOAD, DONE.
  - RUN -> LOAD when i_loadMode=1. Pointer is cleared to 0 on entry.
  - LOAD: o_loadReady=1, o_cpuReset=1, all CPU strobes ignored.
    - Each handshake writes mem[ptr] <= i_loadData, then ptr++.
    - Handshake with ptr==255: ptr wraps to 0, go to DONE.
    - i_loadMode dropping in LOAD goes to RUN immediately. Bytes already written are kept.
  - DONE: o_loadDone=1, o_cpuReset=1, o_loadReady=0. Go to RUN when i_loadMode=0.
  - RUN: o_cpuReset=0, o_loadReady=0, o_loadDone=0.
- Outputs that change on FSM transitions are registered (valid in the cycle after the transition edge).
- Reset mid-load: returns to RUN. Partially loaded RAM is retained.

Optional Feature:
- Macro: MMIO_OUT_EN.
- Defined: a CPU write to MMIO_ADDR updates o_outPort <= i_bus and pulses o_outStrobe for exactly one cycle. RAM at MMIO_ADDR is not written. Reads of MMIO_ADDR return o_outPort.
- Undefined: MMIO_ADDR is ordinary RAM. o_outPort and o_outStrobe are tied to 0.

Test Plan:
- Load: raise i_loadMode and stream bytes 0x00..0xFF with valid held high. Expect 256 accepted bytes, o_loadDone=1 one cycle after the last, o_cpuReset=1 throughout, and mem[k]=k.
- Fetch: i_pc=0x10, i_ctrlPCNOe=0 for one cycle, mem[0x10]=0xA5. Expect o_instruction=0xA5 in the next cycle and holding while i_ctrlPCNOe=1.
- Data write/read: AddressEn with bus=0x20, then WriteEn with bus=0x3C, then i_ctrlRamOE=1. Expect o_bus=0x3C with o_busOE=1 one cycle after the address is valid.
- Simultaneous AddressEn+WriteEn with r_address=0x05 and bus=0x77. Expect mem[0x05]=0x77 and r_address=0x77 afterwards.
- Reset mid-load after 10 bytes. Expect immediate o_loadReady=0, FSM RUN, and mem[0..9] intact.
- MMIO_OUT_EN defined: write 0x5A to 0xFF. Expect o_outPort=0x5A, o_outStrobe high for 1 cycle, and mem[0xFF] unchanged.
